// File: rtl/color_freq_scanner.sv
`default_nettype none
// ============================================================================
// Module      : color_freq_scanner
// Description : Scans NUM_CH photodiode filter channels of a colour light
//               sensor. For each channel it selects the filter, waits for the
//               sensor to settle, then counts sensor_in rising edges over a
//               fixed gate window. After a full frame it publishes all
//               channel counts, the index of the strongest channel and a
//               presence flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   enable       in   level-sensitive scan enable; dropping it aborts a frame
//   sensor_in    in   sensor frequency output (asynchronous to clk)
//   filter_sel   out  filter select (S3,S2); stable throughout a gate window
//   counts       out  channel i count in bits [i*CNT_W +: CNT_W]
//   dominant     out  index of the largest count (ties -> lowest index)
//   detect       out  largest count >= THRESH
//   result_valid out  one-cycle pulse when counts/dominant/detect update
//   busy         out  high whenever the scanner is not idle
// ============================================================================
module color_freq_scanner #(
  parameter int NUM_CH        = 3,
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 100000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int THRESH        = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    sensor_in,
  output logic [1:0]              filter_sel,
  output logic [NUM_CH*CNT_W-1:0] counts,
  output logic [1:0]              dominant,
  output logic                    detect,
  output logic                    result_valid,
  output logic                    busy
);

  // One timer serves both the settle and the gate phase.
  localparam int c_tmr_max = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int c_tmr_w   = $clog2(c_tmr_max + 1);

  localparam logic [c_tmr_w-1:0] c_tmr_one     = c_tmr_w'(1);
  localparam logic [c_tmr_w-1:0] c_settle_last = c_tmr_w'(SETTLE_CYCLES - 1);
  localparam logic [c_tmr_w-1:0] c_gate_last   = c_tmr_w'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   c_cnt_max     = '1;
  localparam logic [CNT_W-1:0]   c_cnt_one     = CNT_W'(1);
  localparam logic [1:0]         c_last_ch     = 2'(NUM_CH - 1);
  localparam logic [63:0]        c_thresh      = 64'(THRESH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_GATE   = 3'd2,
    ST_STORE  = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic                      sync1_q, sync1_d;
  logic                      sync2_q, sync2_d;
  logic                      edge_q, edge_d;
  logic [1:0]                chan_q, chan_d;
  logic [c_tmr_w-1:0]        tmr_q, tmr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          shadow_q [NUM_CH];
  logic [CNT_W-1:0]          shadow_d [NUM_CH];
  logic [1:0]                filter_sel_q, filter_sel_d;
  logic [NUM_CH*CNT_W-1:0]   counts_q, counts_d;
  logic [1:0]                dominant_q, dominant_d;
  logic                      detect_q, detect_d;
  logic                      result_valid_q, result_valid_d;
  logic                      busy_q, busy_d;

  logic                      w_rise;
  logic [CNT_W-1:0]          w_max;
  logic [1:0]                w_dom;

  // Synchronised 0->1 transition of the sensor output.
  assign w_rise = sync2_q & ~edge_q;

  // Strongest channel of the frame held in the shadow slots; strict '>'
  // keeps the lowest index on ties.
  always_comb begin
    w_max = shadow_q[0];
    w_dom = 2'd0;
    for (int i = 1; i < NUM_CH; i++) begin
      if (shadow_q[i] > w_max) begin
        w_max = shadow_q[i];
        w_dom = 2'(i);
      end
    end
  end

  always_comb begin
    sync1_d        = sensor_in;
    sync2_d        = sync1_q;
    edge_d         = sync2_q;
    state_d        = state_q;
    chan_d         = chan_q;
    tmr_d          = tmr_q;
    cnt_d          = cnt_q;
    shadow_d       = shadow_q;
    filter_sel_d   = filter_sel_q;
    counts_d       = counts_q;
    dominant_d     = dominant_q;
    detect_d       = detect_q;
    result_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        chan_d = 2'd0;
        tmr_d  = '0;
        cnt_d  = '0;
        if (enable) begin
          state_d      = ST_SETTLE;
          filter_sel_d = 2'd0;
        end
      end
      ST_SETTLE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (tmr_q == c_settle_last) begin
          state_d = ST_GATE;
          tmr_d   = '0;
          cnt_d   = '0;
        end else begin
          tmr_d = tmr_q + c_tmr_one;
        end
      end
      ST_GATE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
          // Saturate rather than wrap so an overdriven channel still
          // reads as the strongest.
          if (w_rise && (cnt_q != c_cnt_max)) cnt_d = cnt_q + c_cnt_one;
          if (tmr_q == c_gate_last) begin
            state_d = ST_STORE;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + c_tmr_one;
          end
        end
      end
      ST_STORE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (chan_q == 2'(i)) shadow_d[i] = cnt_q;
          end
          tmr_d = '0;
          cnt_d = '0;
          if (chan_q == c_last_ch) begin
            state_d = ST_REPORT;
          end else begin
            chan_d       = chan_q + 2'd1;
            filter_sel_d = chan_q + 2'd1;
            state_d      = ST_SETTLE;
          end
        end
      end
      ST_REPORT: begin
        // All published fields update together from one frame's shadow data.
        for (int i = 0; i < NUM_CH; i++) counts_d[i*CNT_W +: CNT_W] = shadow_q[i];
        dominant_d     = w_dom;
        detect_d       = (64'(w_max) >= c_thresh);
        result_valid_d = 1'b1;
        chan_d         = 2'd0;
        tmr_d          = '0;
        cnt_d          = '0;
        if (enable) begin
          state_d      = ST_SETTLE;
          filter_sel_d = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      edge_q         <= 1'b0;
      chan_q         <= 2'd0;
      tmr_q          <= '0;
      cnt_q          <= '0;
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
      filter_sel_q   <= 2'd0;
      counts_q       <= '0;
      dominant_q     <= 2'd0;
      detect_q       <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      edge_q         <= edge_d;
      chan_q         <= chan_d;
      tmr_q          <= tmr_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      filter_sel_q   <= filter_sel_d;
      counts_q       <= counts_d;
      dominant_q     <= dominant_d;
      detect_q       <= detect_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign filter_sel   = filter_sel_q;
  assign counts       = counts_q;
  assign dominant     = dominant_q;
  assign detect       = detect_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_color_freq_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_color_freq_scanner
// Description : Self-checking bench for color_freq_scanner. A sensor model
//               produces a square wave whose period depends on the selected
//               filter; expected counts are derived from the observed
//               sensor rises and the frame schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_color_freq_scanner;

  localparam int N      = 3;
  localparam int CW     = 16;
  localparam int G      = 100;
  localparam int S      = 10;
  localparam int TH     = 5;
  localparam int CH_LEN = S + G + 1;
  localparam int FRAME  = N * CH_LEN + 1;

  localparam int N2  = 2;
  localparam int CW2 = 4;
  localparam int G2  = 40;
  localparam int S2  = 3;
  localparam int TH2 = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              sensor_in = 1'b0;
  logic [1:0]        filter_sel;
  logic [N*CW-1:0]   counts;
  logic [1:0]        dominant;
  logic              detect;
  logic              result_valid;
  logic              busy;

  logic              enable2;
  logic              sensor2 = 1'b0;
  logic [1:0]        filter_sel2;
  logic [N2*CW2-1:0] counts2;
  logic [1:0]        dominant2;
  logic              detect2;
  logic              result_valid2;
  logic              busy2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int det_q[$];
  logic prev_s = 1'b0;
  int per[4] = '{4, 4, 4, 4};
  int ph     = 0;
  int fs_p   = -1;
  int fs_bad = 0;

  color_freq_scanner #(.NUM_CH(N), .CNT_W(CW), .GATE_CYCLES(G),
                       .SETTLE_CYCLES(S), .THRESH(TH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sensor_in(sensor_in),
    .filter_sel(filter_sel), .counts(counts), .dominant(dominant),
    .detect(detect), .result_valid(result_valid), .busy(busy));

  color_freq_scanner #(.NUM_CH(N2), .CNT_W(CW2), .GATE_CYCLES(G2),
                       .SETTLE_CYCLES(S2), .THRESH(TH2)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable2), .sensor_in(sensor2),
    .filter_sel(filter_sel2), .counts(counts2), .dominant(dominant2),
    .detect(detect2), .result_valid(result_valid2), .busy(busy2));

  always #5 clk = ~clk;

  // Cycle index and sensor rise log: a rise first sampled at posedge k is
  // seen by the counter during cycle k+1 (two sync stages plus edge detect).
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (sensor_in && !prev_s) det_q.push_back(cyc + 1);
    prev_s = sensor_in;
  end

  // Sensor model: period depends on the filter currently selected.
  always @(negedge clk) begin
    ph = ph + 1;
    if (ph >= per[filter_sel]) ph = 0;
    sensor_in = (ph < per[filter_sel] / 2);
    sensor2   = ~sensor2;
  end

  // filter_sel must equal the scheduled channel throughout each gate window.
  always @(negedge clk) begin : fs_mon
    int off, c, w;
    if (fs_p >= 0 && cyc >= fs_p) begin
      off = (cyc - fs_p) % FRAME;
      c   = off / CH_LEN;
      w   = off % CH_LEN;
      if (c < N && w >= S && w < S + G && filter_sel !== 2'(c)) fs_bad++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt(input int gs, input int len, input int maxv);
    int n = 0;
    foreach (det_q[i]) if (det_q[i] >= gs && det_q[i] < gs + len) n++;
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic check_frame(input string tag, input int p);
    int e[N];
    int mx, dom;
    for (int c = 0; c < N; c++) e[c] = exp_cnt(p + c * CH_LEN + S, G, 65535);
    mx = e[0];
    dom = 0;
    for (int c = 1; c < N; c++) if (e[c] > mx) begin mx = e[c]; dom = c; end
    for (int c = 0; c < N; c++) chk($sformatf("%s_count%0d", tag, c), 64'(counts[c*CW +: CW]), 64'(e[c]));
    chk({tag, "_dominant"}, 64'(dominant), 64'(dom));
    chk({tag, "_detect"}, 64'(detect), 64'(mx >= TH));
  endtask

  task automatic wait_rv(input string tag, input int exp_cyc);
    int got = -1;
    for (int i = 0; i < 3 * FRAME && got < 0; i++) begin
      @(negedge clk);
      if (result_valid) got = cyc;
    end
    chk({tag, "_rv_cycle"}, 64'(got), 64'(exp_cyc));
  endtask

  task automatic start(output int p);
    @(negedge clk);
    enable = 1'b1;
    p      = cyc + 1;
    fs_p   = p;
  endtask

  task automatic run_single(input string tag);
    int p;
    start(p);
    @(negedge clk);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_rv(tag, p + N * CH_LEN + 1);
    check_frame(tag, p);
    enable = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(result_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    fs_p = -1;
  endtask

  initial begin
    int p, rv_cnt, fs_chg, guard;
    logic [N*CW-1:0] prev_counts;
    logic [1:0] prev_fs;

    reset   = 1'b1;
    enable  = 1'b0;
    enable2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_filter_sel", 64'(filter_sel), 64'd0);
    chk("rst_counts", 64'(counts), 64'd0);
    chk("rst_dominant", 64'(dominant), 64'd0);
    chk("rst_detect", 64'(detect), 64'd0);
    chk("rst_result_valid", 64'(result_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame: periods 10/20/50.
    per[0] = 10; per[1] = 20; per[2] = 50;
    run_single("basic");

    // Tie between ch1 and ch2 with all counts below threshold.
    per[0] = 50; per[1] = 25; per[2] = 25;
    run_single("tie");

    // Random sensor periods.
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < N; c++) per[c] = $urandom_range(2, 40);
      run_single($sformatf("rand%0d", f));
    end

    // Abort mid ch1 gate: outputs hold, no result.
    for (int c = 0; c < N; c++) per[c] = $urandom_range(2, 30);
    prev_counts = counts;
    start(p);
    guard = 0;
    while (cyc < p + CH_LEN + S + 50 && guard < 5000) begin @(negedge clk); guard++; end
    enable = 1'b0;
    fs_p   = -1;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    rv_cnt  = 0;
    fs_chg  = 0;
    prev_fs = filter_sel;
    repeat (300) begin
      @(negedge clk);
      if (result_valid) rv_cnt++;
      if (filter_sel !== prev_fs) fs_chg++;
    end
    chk("abort_no_rv", 64'(rv_cnt), 64'd0);
    chk("abort_fs_quiet", 64'(fs_chg), 64'd0);
    chk("abort_counts_held", 64'(counts), 64'(prev_counts));
    run_single("reenable");

    // Continuous run: three back-to-back frames.
    for (int c = 0; c < N; c++) per[c] = $urandom_range(2, 40);
    start(p);
    for (int k = 0; k < 3; k++) begin
      wait_rv($sformatf("cont%0d", k), p + k * FRAME + N * CH_LEN + 1);
      check_frame($sformatf("cont%0d", k), p + k * FRAME);
      for (int c = 0; c < N; c++) per[c] = $urandom_range(2, 40);
    end
    enable = 1'b0;
    fs_p   = -1;
    chk("filter_sel_stable_in_gate", 64'(fs_bad), 64'd0);
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a gate window.
    start(p);
    guard = 0;
    while (cyc < p + S + 20 && guard < 5000) begin @(negedge clk); guard++; end
    fs_p = -1;
    #2 reset = 1'b1;
    #1;
    chk("arst_counts", 64'(counts), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_filter_sel", 64'(filter_sel), 64'd0);
    chk("arst_dominant", 64'(dominant), 64'd0);
    chk("arst_detect", 64'(detect), 64'd0);
    chk("arst_result_valid", 64'(result_valid), 64'd0);
    enable = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    rv_cnt = 0;
    fs_chg = 0;
    repeat (300) begin
      @(negedge clk);
      if (result_valid) rv_cnt++;
      if (filter_sel !== 2'd0 || busy) fs_chg++;
    end
    chk("idle_no_rv", 64'(rv_cnt), 64'd0);
    chk("idle_quiet", 64'(fs_chg), 64'd0);

    // Saturation: 4-bit counters, sensor rising every other cycle.
    @(negedge clk);
    enable2 = 1'b1;
    p = cyc + 1;
    guard = -1;
    for (int i = 0; i < 500 && guard < 0; i++) begin
      @(negedge clk);
      if (result_valid2) guard = cyc;
    end
    enable2 = 1'b0;
    chk("sat_rv_cycle", 64'(guard), 64'(p + N2 * (S2 + G2 + 1) + 1));
    chk("sat_count0", 64'(counts2[0 +: CW2]), 64'd15);
    chk("sat_count1", 64'(counts2[CW2 +: CW2]), 64'd15);
    chk("sat_dominant", 64'(dominant2), 64'd0);
    chk("sat_detect", 64'(detect2), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
